// File: rtl/ysyx_25040129_mem_arbiter_pkg.sv
// Shared types and AXI constants for the ICACHE/LSU memory-port arbiter.
// Combinational content only; no latency or backpressure of its own.
package ysyx_25040129_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_AR,
    I_R,
    L_AR,
    L_R,
    L_W,
    L_B
  } state_t;

  localparam logic MST_ICACHE = 1'b0;
  localparam logic MST_LSU    = 1'b1;

  localparam logic [1:0] OKAY       = 2'b00;
  localparam logic [1:0] SLVERR     = 2'b10;
  localparam logic [1:0] DECERR     = 2'b11;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/ysyx_25040129_arb_pick.sv
// ICACHE/LSU request picker, purely combinational, no backpressure.
// YSYX_25040129_ARB_RR_EN selects round-robin on i_ptr; otherwise LSU has fixed priority.
module ysyx_25040129_arb_pick
  import ysyx_25040129_mem_arbiter_pkg::*;
(
  input  logic i_req_icache,
  input  logic i_req_lsu,
  input  logic i_ptr,
  output logic o_gnt_vld,
  output logic o_gnt_id
);

  assign o_gnt_vld = i_req_icache | i_req_lsu;

`ifdef YSYX_25040129_ARB_RR_EN
  // i_ptr names the master that was not granted last; it wins a tie.
  always_comb begin
    if (i_req_icache && i_req_lsu) begin
      o_gnt_id = i_ptr;
    end else if (i_req_lsu) begin
      o_gnt_id = MST_LSU;
    end else begin
      o_gnt_id = MST_ICACHE;
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;
  assign o_gnt_id     = i_req_lsu ? MST_LSU : MST_ICACHE;
`endif

endmodule

// File: rtl/ysyx_25040129_mem_arbiter.sv
// Two-master AXI4 arbiter; one whole transaction granted at a time, 1-cycle IDLE bubble per grant.
// Channels are passed combinationally to the owner, so backpressure flows straight through; YSYX_25040129_ARB_RR_EN selects round-robin.
module ysyx_25040129_mem_arbiter
  import ysyx_25040129_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // ICACHE
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [1:0]          i_arburst,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic [1:0]          i_rresp,
  output logic                i_rlast,
  output logic                i_rvalid,
  input  logic                i_rready,
  // LSU
  input  logic [ADDR_W-1:0]   l_araddr,
  input  logic [2:0]          l_arsize,
  input  logic                l_arvalid,
  output logic                l_arready,
  output logic [DATA_W-1:0]   l_rdata,
  output logic [1:0]          l_rresp,
  output logic                l_rvalid,
  input  logic                l_rready,
  input  logic [ADDR_W-1:0]   l_awaddr,
  input  logic [2:0]          l_awsize,
  input  logic                l_awvalid,
  output logic                l_awready,
  input  logic [DATA_W-1:0]   l_wdata,
  input  logic [DATA_W/8-1:0] l_wstrb,
  input  logic                l_wvalid,
  output logic                l_wready,
  output logic [1:0]          l_bresp,
  output logic                l_bvalid,
  input  logic                l_bready,
  // downstream
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  // ICACHE carries no arsize, so its bursts always use full-width beats.
  localparam logic [2:0] ICACHE_SIZE = 3'($clog2(DATA_W / 8));

  state_t r_state;
  state_t w_state_nxt;
  logic   r_aw_done;
  logic   r_w_done;
  logic   r_ptr;
  logic   w_aw_done_nxt;
  logic   w_w_done_nxt;
  logic   w_ptr_nxt;
  logic   w_gnt_vld;
  logic   w_gnt_id;

  ysyx_25040129_arb_pick u_pick (
    .i_req_icache (i_arvalid),
    .i_req_lsu    (l_arvalid | l_awvalid),
    .i_ptr        (r_ptr),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt_id     (w_gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ptr     <= MST_ICACHE;
    end else begin
      r_state   <= w_state_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_comb begin
    i_arready = 1'b0; i_rdata = '0; i_rresp = OKAY; i_rlast = 1'b0; i_rvalid = 1'b0;
    l_arready = 1'b0; l_rdata = '0; l_rresp = OKAY; l_rvalid = 1'b0;
    l_awready = 1'b0; l_wready = 1'b0; l_bresp = OKAY; l_bvalid = 1'b0;
    m_araddr  = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awaddr  = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = 1'b0;
    m_wdata   = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
    m_bready  = 1'b0;
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_ptr_nxt     = r_ptr;
    // Outputs stay quiet while rst is high, even before the reset edge lands.
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            if (w_gnt_id == MST_ICACHE) w_state_nxt = I_AR;
            else if (l_arvalid)         w_state_nxt = L_AR;
            else                        w_state_nxt = L_W;
          end
        end
        I_AR: begin
          m_araddr  = i_araddr;
          m_arlen   = i_arlen;
          m_arsize  = ICACHE_SIZE;
          m_arburst = i_arburst;
          m_arvalid = i_arvalid;
          i_arready = m_arready;
          if (i_arvalid && m_arready) w_state_nxt = I_R;
        end
        I_R: begin
          i_rdata  = m_rdata;
          i_rresp  = m_rresp;
          i_rlast  = m_rlast;
          i_rvalid = m_rvalid;
          m_rready = i_rready;
          if (m_rvalid && i_rready && m_rlast) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = MST_LSU;
          end
        end
        L_AR: begin
          m_araddr  = l_araddr;
          m_arlen   = 8'd0;
          m_arsize  = l_arsize;
          m_arburst = BURST_INCR;
          m_arvalid = l_arvalid;
          l_arready = m_arready;
          if (l_arvalid && m_arready) w_state_nxt = L_R;
        end
        L_R: begin
          l_rdata  = m_rdata;
          l_rresp  = m_rresp;
          l_rvalid = m_rvalid;
          m_rready = l_rready;
          if (m_rvalid && l_rready && m_rlast) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = MST_ICACHE;
          end
        end
        L_W: begin
          m_awaddr  = l_awaddr;
          m_awlen   = 8'd0;
          m_awsize  = l_awsize;
          m_awburst = BURST_INCR;
          m_awvalid = l_awvalid & ~r_aw_done;
          l_awready = m_awready & ~r_aw_done;
          m_wdata   = l_wdata;
          m_wstrb   = l_wstrb;
          m_wlast   = 1'b1;
          m_wvalid  = l_wvalid & ~r_w_done;
          l_wready  = m_wready & ~r_w_done;
          w_aw_done_nxt = r_aw_done | (m_awvalid & m_awready);
          w_w_done_nxt  = r_w_done | (m_wvalid & m_wready);
          if (w_aw_done_nxt && w_w_done_nxt) begin
            w_state_nxt   = L_B;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
          end
        end
        L_B: begin
          l_bresp  = m_bresp;
          l_bvalid = m_bvalid;
          m_bready = l_bready;
          if (m_bvalid && l_bready) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = MST_ICACHE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Directed self-checking bench for the ICACHE/LSU memory arbiter.
// Honours YSYX_25040129_ARB_RR_EN when computing the expected grant order.
module tb_ysyx_25040129_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_araddr = '0;
  logic [7:0]  i_arlen = '0;
  logic [1:0]  i_arburst = '0;
  logic        i_arvalid = 1'b0, i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rlast, i_rvalid;
  logic        i_rready = 1'b0;
  logic [31:0] l_araddr = '0;
  logic [2:0]  l_arsize = '0;
  logic        l_arvalid = 1'b0, l_arready;
  logic [31:0] l_rdata;
  logic [1:0]  l_rresp;
  logic        l_rvalid;
  logic        l_rready = 1'b0;
  logic [31:0] l_awaddr = '0;
  logic [2:0]  l_awsize = '0;
  logic        l_awvalid = 1'b0, l_awready;
  logic [31:0] l_wdata = '0;
  logic [3:0]  l_wstrb = '0;
  logic        l_wvalid = 1'b0, l_wready;
  logic [1:0]  l_bresp;
  logic        l_bvalid;
  logic        l_bready = 1'b0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0, m_rvalid = 1'b0, m_rready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0, m_bready;

  int checks = 0;
  int failures = 0;

  ysyx_25040129_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .i_rready(i_rready),
    .l_araddr(l_araddr), .l_arsize(l_arsize), .l_arvalid(l_arvalid), .l_arready(l_arready),
    .l_rdata(l_rdata), .l_rresp(l_rresp), .l_rvalid(l_rvalid), .l_rready(l_rready),
    .l_awaddr(l_awaddr), .l_awsize(l_awsize), .l_awvalid(l_awvalid), .l_awready(l_awready),
    .l_wdata(l_wdata), .l_wstrb(l_wstrb), .l_wvalid(l_wvalid), .l_wready(l_wready),
    .l_bresp(l_bresp), .l_bvalid(l_bvalid), .l_bready(l_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_arvalid = 1'b1; l_arvalid = 1'b1; l_awvalid = 1'b1; l_wvalid = 1'b1;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
    i_rready = 1'b1; l_rready = 1'b1; l_bready = 1'b1;
    step();
    @(negedge clk);
    checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL rst_m_arvalid got=%0b exp=0", m_arvalid); end
    checks++; if (m_awvalid !== 1'b0) begin failures++; $display("FAIL rst_m_awvalid got=%0b exp=0", m_awvalid); end
    checks++; if (m_wvalid !== 1'b0) begin failures++; $display("FAIL rst_m_wvalid got=%0b exp=0", m_wvalid); end
    checks++; if ({m_rready, m_bready} !== 2'b00) begin failures++; $display("FAIL rst_m_ready got=%b exp=00", {m_rready, m_bready}); end
    checks++; if ({i_arready, l_arready, l_awready, l_wready} !== 4'b0) begin failures++; $display("FAIL rst_up_ready got=%b exp=0000", {i_arready, l_arready, l_awready, l_wready}); end
    checks++; if ({i_rvalid, l_rvalid, l_bvalid} !== 3'b0) begin failures++; $display("FAIL rst_up_valid got=%b exp=000", {i_rvalid, l_rvalid, l_bvalid}); end
    i_arvalid = 1'b0; l_arvalid = 1'b0; l_awvalid = 1'b0; l_wvalid = 1'b0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
    i_rready = 1'b0; l_rready = 1'b0; l_bready = 1'b0;
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL post_rst_idle got=%0b exp=0", m_arvalid); end
    step();
  endtask

  task automatic test_icache_burst();
    i_araddr = 32'h8000_0010; i_arlen = 8'd1; i_arburst = 2'b01; i_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL ic_idle_bubble got=%0b exp=0", m_arvalid); end
    step();
    m_arready = 1'b1;
    @(negedge clk);
    checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL ic_m_arvalid got=%0b exp=1", m_arvalid); end
    checks++; if (m_araddr !== 32'h8000_0010) begin failures++; $display("FAIL ic_m_araddr got=%h exp=80000010", m_araddr); end
    checks++; if (m_arlen !== 8'd1) begin failures++; $display("FAIL ic_m_arlen got=%0d exp=1", m_arlen); end
    checks++; if (i_arready !== 1'b1) begin failures++; $display("FAIL ic_i_arready got=%0b exp=1", i_arready); end
    step();
    i_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h11; m_rlast = 1'b0; m_rresp = 2'b00; i_rready = 1'b1;
    @(negedge clk);
    checks++; if ({i_rvalid, i_rlast} !== 2'b10) begin failures++; $display("FAIL ic_beat1_vld_last got=%b exp=10", {i_rvalid, i_rlast}); end
    checks++; if (i_rdata !== 32'h11) begin failures++; $display("FAIL ic_beat1_data got=%h exp=11", i_rdata); end
    step();
    m_rdata = 32'h22; m_rlast = 1'b1;
    @(negedge clk);
    checks++; if ({i_rvalid, i_rlast} !== 2'b11) begin failures++; $display("FAIL ic_beat2_vld_last got=%b exp=11", {i_rvalid, i_rlast}); end
    checks++; if (i_rdata !== 32'h22) begin failures++; $display("FAIL ic_beat2_data got=%h exp=22", i_rdata); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0; i_rready = 1'b0;
    @(negedge clk);
    checks++; if ({i_rvalid, m_rready, m_arvalid} !== 3'b000) begin failures++; $display("FAIL ic_back_idle got=%b exp=000", {i_rvalid, m_rready, m_arvalid}); end
    step();
  endtask

  task automatic test_lsu_write();
    int aw_cnt = 0;
    int w_cnt = 0;
    l_awaddr = 32'h8000_1000; l_awsize = 3'd2; l_awvalid = 1'b1;
    l_wdata = 32'hDEAD_BEEF; l_wstrb = 4'hF; l_wvalid = 1'b1; l_bready = 1'b1;
    @(negedge clk);
    checks++; if (m_awvalid !== 1'b0) begin failures++; $display("FAIL wr_idle_bubble got=%0b exp=0", m_awvalid); end
    step();
    // awready is held high throughout; the LSU keeps awvalid up to probe the masking.
    m_awready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      m_wready = (c == 2);
      @(negedge clk);
      aw_cnt += int'(m_awvalid && m_awready);
      w_cnt  += int'(m_wvalid && m_wready);
      if (c == 0) begin
        checks++; if ({m_awvalid, m_wvalid, m_wlast} !== 3'b111) begin failures++; $display("FAIL wr_first_vld got=%b exp=111", {m_awvalid, m_wvalid, m_wlast}); end
        checks++; if ({m_awaddr, m_wdata} !== {32'h8000_1000, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wr_payload got=%h_%h exp=80001000_deadbeef", m_awaddr, m_wdata); end
        checks++; if ({m_wstrb, m_awlen, m_awburst, m_awsize} !== {4'hF, 8'd0, 2'b01, 3'd2}) begin failures++; $display("FAIL wr_ctl got=%h/%0d/%b/%0d exp=f/0/01/2", m_wstrb, m_awlen, m_awburst, m_awsize); end
      end
      if (c == 1) begin
        checks++; if ({m_awvalid, l_awready, m_wvalid} !== 3'b001) begin failures++; $display("FAIL wr_aw_masked got=%b exp=001", {m_awvalid, l_awready, m_wvalid}); end
      end
      step();
    end
    l_awvalid = 1'b0; l_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge clk);
    checks++; if ({l_bvalid, m_bready, m_wvalid} !== 3'b110) begin failures++; $display("FAIL wr_b_phase got=%b exp=110", {l_bvalid, m_bready, m_wvalid}); end
    checks++; if (l_bresp !== 2'b00) begin failures++; $display("FAIL wr_bresp got=%b exp=00", l_bresp); end
    checks++; if (aw_cnt !== 1) begin failures++; $display("FAIL wr_aw_hs_count got=%0d exp=1", aw_cnt); end
    checks++; if (w_cnt !== 1) begin failures++; $display("FAIL wr_w_hs_count got=%0d exp=1", w_cnt); end
    step();
    m_bvalid = 1'b0; l_bready = 1'b0;
    @(negedge clk);
    checks++; if ({l_bvalid, m_awvalid} !== 2'b00) begin failures++; $display("FAIL wr_back_idle got=%b exp=00", {l_bvalid, m_awvalid}); end
    step();
  endtask

  task automatic test_write_same_cycle();
    l_awaddr = 32'h8000_1100; l_awsize = 3'd2; l_awvalid = 1'b1;
    l_wdata = 32'h0000_00A5; l_wstrb = 4'h1; l_wvalid = 1'b1; l_bready = 1'b1;
    step();
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk);
    checks++; if ({m_awvalid, m_wvalid} !== 2'b11) begin failures++; $display("FAIL wsc_both_vld got=%b exp=11", {m_awvalid, m_wvalid}); end
    step();
    l_awvalid = 1'b0; l_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b10;
    @(negedge clk);
    checks++; if ({l_bvalid, l_bresp} !== 3'b110) begin failures++; $display("FAIL wsc_b_slverr got=%b exp=110", {l_bvalid, l_bresp}); end
    step();
    m_bvalid = 1'b0; m_bresp = 2'b00; l_bready = 1'b0;
    @(negedge clk);
    checks++; if (l_bvalid !== 1'b0) begin failures++; $display("FAIL wsc_back_idle got=%0b exp=0", l_bvalid); end
    step();
  endtask

  task automatic test_lsu_rd_before_wr();
    l_araddr = 32'h8000_2000; l_arsize = 3'd2; l_arvalid = 1'b1;
    l_awaddr = 32'h8000_3000; l_awsize = 3'd2; l_awvalid = 1'b1;
    l_wdata = 32'h1234_5678; l_wstrb = 4'hF; l_wvalid = 1'b1;
    step();
    m_arready = 1'b1;
    @(negedge clk);
    checks++; if ({m_arvalid, m_awvalid, l_arready} !== 3'b101) begin failures++; $display("FAIL rw_read_first got=%b exp=101", {m_arvalid, m_awvalid, l_arready}); end
    checks++; if ({m_araddr, m_arlen, m_arburst, m_arsize} !== {32'h8000_2000, 8'd0, 2'b01, 3'd2}) begin failures++; $display("FAIL rw_ar_payload got=%h/%0d/%b/%0d exp=80002000/0/01/2", m_araddr, m_arlen, m_arburst, m_arsize); end
    step();
    l_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rresp = 2'b11; m_rdata = 32'h0000_0BAD; l_rready = 1'b1;
    @(negedge clk);
    checks++; if ({l_rvalid, l_rresp} !== 3'b111) begin failures++; $display("FAIL rw_decerr got=%b exp=111", {l_rvalid, l_rresp}); end
    checks++; if (l_rdata !== 32'h0000_0BAD) begin failures++; $display("FAIL rw_rdata got=%h exp=00000bad", l_rdata); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; l_rready = 1'b0;
    @(negedge clk);
    checks++; if ({l_rvalid, m_awvalid, m_arvalid} !== 3'b000) begin failures++; $display("FAIL rw_idle_between got=%b exp=000", {l_rvalid, m_awvalid, m_arvalid}); end
    step();
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk);
    checks++; if ({m_awvalid, m_wvalid} !== 2'b11 || m_awaddr !== 32'h8000_3000) begin failures++; $display("FAIL rw_write_next got=%b/%h exp=11/80003000", {m_awvalid, m_wvalid}, m_awaddr); end
    step();
    l_awvalid = 1'b0; l_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; l_bready = 1'b1;
    @(negedge clk);
    checks++; if (l_bvalid !== 1'b1) begin failures++; $display("FAIL rw_bvalid got=%0b exp=1", l_bvalid); end
    step();
    m_bvalid = 1'b0; l_bready = 1'b0;
  endtask

  task automatic test_concurrent_reads();
    logic exp_l;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      i_araddr = 32'h8000_0100; i_arlen = 8'd0; i_arburst = 2'b01; i_arvalid = 1'b1;
      l_araddr = 32'h8000_0200; l_arsize = 3'd2; l_arvalid = 1'b1;
      step();
      m_arready = 1'b1;
`ifdef YSYX_25040129_ARB_RR_EN
      exp_l = ((r % 2) == 1);
`else
      exp_l = 1'b1;
`endif
      @(negedge clk);
      checks++; if ({l_arready, i_arready} !== {exp_l, ~exp_l}) begin failures++; $display("FAIL cc_grant_r%0d got=l%0b/i%0b exp=l%0b/i%0b", r, l_arready, i_arready, exp_l, ~exp_l); end
      checks++; if (m_araddr !== (exp_l ? 32'h8000_0200 : 32'h8000_0100)) begin failures++; $display("FAIL cc_addr_r%0d got=%h exp_lsu=%0b", r, m_araddr, exp_l); end
      step();
      m_arready = 1'b0;
      if (exp_l) l_arvalid = 1'b0; else i_arvalid = 1'b0;
      m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'(r); i_rready = 1'b1; l_rready = 1'b1;
      @(negedge clk);
      checks++; if ({l_rvalid, i_rvalid} !== {exp_l, ~exp_l}) begin failures++; $display("FAIL cc_rvalid_r%0d got=l%0b/i%0b exp=l%0b/i%0b", r, l_rvalid, i_rvalid, exp_l, ~exp_l); end
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0; i_rready = 1'b0; l_rready = 1'b0;
    end
    // Whichever master lost the last round withdraws while IDLE; it must not be granted.
    i_arvalid = 1'b0; l_arvalid = 1'b0;
    step();
    @(negedge clk);
    checks++; if ({m_arvalid, i_arready, l_arready} !== 3'b000) begin failures++; $display("FAIL cc_withdrawn got=%b exp=000", {m_arvalid, i_arready, l_arready}); end
    step();
  endtask

  task automatic test_reset_mid();
    i_araddr = 32'h8000_0040; i_arlen = 8'd1; i_arburst = 2'b01; i_arvalid = 1'b1;
    step();
    m_arready = 1'b1;
    step();
    i_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h33; m_rlast = 1'b0; i_rready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({i_rvalid, m_rready} !== 2'b00) begin failures++; $display("FAIL rm_during_rst got=%b exp=00", {i_rvalid, m_rready}); end
    step();
    rst = 1'b0; m_rvalid = 1'b0; i_rready = 1'b0;
    @(negedge clk);
    checks++; if ({i_rvalid, m_rready, m_arvalid} !== 3'b000) begin failures++; $display("FAIL rm_after_rst got=%b exp=000", {i_rvalid, m_rready, m_arvalid}); end
    // With the ICACHE quiet, m_rvalid pulsing here must not reach it.
    m_rvalid = 1'b1; i_rready = 1'b1;
    @(posedge clk);
    #1;
    m_rvalid = 1'b0; i_rready = 1'b0;
    l_araddr = 32'h8000_4000; l_arsize = 3'd2; l_arvalid = 1'b1;
    step();
    m_arready = 1'b1;
    @(negedge clk);
    checks++; if ({l_arready, m_arvalid, m_arlen} !== {1'b1, 1'b1, 8'd0}) begin failures++; $display("FAIL rm_lsu_ar got=%0b/%0b/%0d exp=1/1/0", l_arready, m_arvalid, m_arlen); end
    step();
    l_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hCAFE_0001; m_rresp = 2'b00; l_rready = 1'b1;
    @(negedge clk);
    checks++; if ({l_rvalid, l_rresp, l_rdata} !== {1'b1, 2'b00, 32'hCAFE_0001}) begin failures++; $display("FAIL rm_lsu_r got=%0b/%b/%h exp=1/00/cafe0001", l_rvalid, l_rresp, l_rdata); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0; l_rready = 1'b0;
    @(negedge clk);
    checks++; if (l_rvalid !== 1'b0) begin failures++; $display("FAIL rm_lsu_done got=%0b exp=0", l_rvalid); end
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_icache_burst();
    test_lsu_write();
    test_write_same_cycle();
    test_lsu_rd_before_wr();
    test_concurrent_reads();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
